// File: rtl/nibble_add_seq_if.sv
// nibble_add_seq_if: request/operand/result bundle shared by requesters and the nibble adder
interface nibble_add_seq_if #(parameter int NIB = 4);
  logic [1:0] req;
  logic [4*NIB-1:0] a0, b0, a1, b1, sum;
  logic busy, gnt_id, done, cout;
  modport master(output req, a0, b0, a1, b1, input busy, gnt_id, done, sum, cout);
  modport slave(input req, a0, b0, a1, b1, output busy, gnt_id, done, sum, cout);
endinterface

// File: rtl/nibble_add_seq.sv
// nibble_add_seq: two-requester round-robin W-bit adder built from one time-multiplexed nibble adder
module nibble_add_seq #(parameter int NIB = 4) (
  input logic clk,
  input logic rst_n,
  nibble_add_seq_if.slave bus
);
  localparam int W = 4 * NIB;
  localparam int IW = NIB > 1 ? $clog2(NIB) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [W-1:0] ra, rb, acc, acc_nxt;
  logic [IW-1:0] idx;
  logic carry, ptr, g;
  logic [4:0] nsum;
  assign g = &bus.req ? ptr : bus.req[1];
  assign nsum = {1'b0, ra[{idx, 2'b00} +: 4]} + {1'b0, rb[{idx, 2'b00} +: 4]} + {4'b0, carry};
  assign bus.busy = state != IDLE;
  // partial results build up here so sum only ever shows complete additions
  always_comb begin
    acc_nxt = acc;
    acc_nxt[{idx, 2'b00} +: 4] = nsum[3:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      acc <= '0;
      idx <= '0;
      carry <= 1'b0;
      ptr <= 1'b0;
      bus.gnt_id <= 1'b0;
      bus.done <= 1'b0;
      bus.sum <= '0;
      bus.cout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|bus.req) begin
          ra <= g ? bus.a1 : bus.a0;
          rb <= g ? bus.b1 : bus.b0;
          carry <= 1'b0;
          idx <= '0;
          ptr <= ~g;
          bus.gnt_id <= g;
          state <= RUN;
        end
        RUN: begin
          acc <= acc_nxt;
          carry <= nsum[4];
          idx <= idx + 1'b1;
          if (idx == IW'(NIB - 1)) begin
            bus.sum <= acc_nxt;
            bus.cout <= nsum[4];
            bus.done <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          bus.done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_add_seq.sv
// tb_nibble_add_seq: vector table plus hand sequences, results checked through an expectation queue
module tb_nibble_add_seq;
  typedef struct {
    logic [1:0] req;
    logic [15:0] a0, b0, a1, b1;
    logic exp_id;
    logic [15:0] exp_sum;
    logic exp_cout;
  } vec_t;
  typedef struct {
    logic id;
    logic [15:0] sum;
    logic cout;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int n_done = 0;
  int n_exp = 0;
  exp_t sb[$];
  vec_t vecs[8];
  nibble_add_seq_if #(.NIB(4)) bus();
  nibble_add_seq #(.NIB(4)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (bus.done) begin
      n_done++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (sum %0h)", bus.sum);
      end else begin
        e = sb.pop_front();
        check("gnt_id", {31'b0, bus.gnt_id}, {31'b0, e.id});
        check("sum", {16'b0, bus.sum}, {16'b0, e.sum});
        check("cout", {31'b0, bus.cout}, {31'b0, e.cout});
      end
    end
  end
  task automatic push_exp(input logic id, input logic [15:0] s, input logic c);
    exp_t e;
    e.id = id;
    e.sum = s;
    e.cout = c;
    sb.push_back(e);
    n_exp++;
  endtask
  task automatic do_op(input vec_t v);
    int lat;
    lat = 0;
    @(negedge clk);
    bus.req = v.req;
    bus.a0 = v.a0;
    bus.b0 = v.b0;
    bus.a1 = v.a1;
    bus.b1 = v.b1;
    push_exp(v.exp_id, v.exp_sum, v.exp_cout);
    @(posedge clk);
    #1;
    bus.req = 2'b00;
    bus.a0 = 16'($urandom);
    bus.b0 = 16'($urandom);
    bus.a1 = 16'($urandom);
    bus.b1 = 16'($urandom);
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) check("busy_run", {31'b0, bus.busy}, 32'd1);
      if (bus.done) lat = k;
    end
    check("latency", lat, 32'd5);
    @(negedge clk);
    check("done_one_cycle", {31'b0, bus.done}, 32'd0);
  endtask
  initial begin
    int t[4];
    int nd;
    int lat;
    vecs[0] = '{2'b01, 16'h1234, 16'h4321, 16'h0000, 16'h0000, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{2'b10, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1};
    vecs[2] = '{2'b11, 16'h0F0F, 16'h00F1, 16'h8000, 16'h8000, 1'b0, 16'h1000, 1'b0};
    vecs[3] = '{2'b11, 16'h0F0F, 16'h00F1, 16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1};
    vecs[4] = '{2'b10, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0};
    vecs[5] = '{2'b11, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 16'hFFFE, 1'b1};
    vecs[6] = '{2'b01, 16'h8421, 16'h7BDF, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1};
    vecs[7] = '{2'b11, 16'h0000, 16'h0000, 16'hABCD, 16'h1234, 1'b1, 16'hBE01, 1'b0};
    bus.req = 2'b00;
    bus.a0 = '0;
    bus.b0 = '0;
    bus.a1 = '0;
    bus.b1 = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_gnt", {31'b0, bus.gnt_id}, 32'd0);
    check("rst_sum", {16'b0, bus.sum}, 32'd0);
    check("rst_cout", {31'b0, bus.cout}, 32'd0);
    rst_n = 1'b1;
    foreach (vecs[i]) do_op(vecs[i]);
    // abort a requester-1 operation mid-run with an asynchronous reset
    @(negedge clk);
    bus.req = 2'b10;
    bus.a1 = 16'h0001;
    bus.b1 = 16'h0001;
    @(posedge clk);
    #1;
    bus.req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_sum", {16'b0, bus.sum}, 32'd0);
    check("abort_cout", {31'b0, bus.cout}, 32'd0);
    check("abort_gnt", {31'b0, bus.gnt_id}, 32'd0);
    bus.req = 2'b01;
    bus.a0 = 16'h0101;
    bus.b0 = 16'h0202;
    push_exp(1'b0, 16'h0303, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        bus.req = 2'b00;
      end
    end
    check("latency_after_reset", lat, 32'd5);
    // back-to-back service with both requests held
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.a0 = 16'h0F0F;
    bus.b0 = 16'h00F1;
    bus.a1 = 16'h8000;
    bus.b1 = 16'h8000;
    for (int i = 0; i < 4; i++) push_exp(i[0], i[0] ? 16'h0000 : 16'h1000, i[0]);
    bus.req = 2'b11;
    nd = 0;
    for (int cyc = 1; cyc <= 60 && nd < 4; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        t[nd] = cyc;
        nd++;
        if (nd == 4) bus.req = 2'b00;
      end
    end
    check("b2b_count", nd, 32'd4);
    for (int i = 1; i < nd; i++) check("b2b_spacing", t[i] - t[i-1], 32'd6);
    repeat (10) @(negedge clk);
    check("queue_empty", sb.size(), 32'd0);
    check("done_count", n_done, n_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/nibble_add_seq.md
NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 Parameter: NIB, default 4, number of 4-bit nibbles per operand; operand width W = 4*NIB.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  2  per-requester request; req[i] high = requester i asks for an addition.
REQ-005 a0, b0  input  W each  requester-0 operands.
REQ-006 a1, b1  input  W each  requester-1 operands.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 gnt_id  output  1  index of the requester currently being served; holds its last value in IDLE.
REQ-009 done  output  1  one-cycle pulse; result for gnt_id is valid.
REQ-010 sum  output  W  result of the last completed addition.
REQ-011 cout  output  1  carry-out of the last completed addition.

Function
REQ-012 The block SHALL contain exactly one 4-bit ripple-carry nibble adder with carry-in; all W-bit additions SHALL be done by time-multiplexing it, least significant nibble first.
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 IDLE: if any req bit is high at a rising edge, the block SHALL grant one requester, latch its a/b into internal registers, clear the carry register, set nibble index to 0, set gnt_id and go to RUN; otherwise it SHALL stay in IDLE.
REQ-015 Arbitration SHALL be round-robin using a 1-bit pointer: a single requester is always granted; if both are requesting, the requester named by the pointer wins; after every grant the pointer SHALL point to the other requester.
REQ-016 RUN: on each edge the block SHALL add latched nibble[idx] of A and B plus the carry register, write the 4-bit result into sum-register nibble[idx], store the nibble carry-out, and increment idx.
REQ-017 The block SHALL leave RUN for DONE on the edge that processes idx = NIB-1.
REQ-018 DONE SHALL last exactly one cycle: done = 1 and the block SHALL return to IDLE on the next edge.
REQ-019 sum and cout SHALL update only on the transition into DONE and SHALL hold until the next completed operation. Partial nibbles SHALL NOT be visible on sum.
REQ-020 Latency: done SHALL be high in the cycle after the NIB-th RUN edge, i.e. NIB+1 edges after the grant edge. Back-to-back throughput SHALL be one operation per NIB+2 cycles.
REQ-021 Changes on a0/b0/a1/b1 after the grant edge SHALL NOT affect the running operation.
REQ-022 Deasserting req during RUN SHALL NOT abort the operation; done still pulses.
REQ-023 A requester SHALL treat done with matching gnt_id as its acknowledge. If its req is still high in the next IDLE cycle, it SHALL be treated as a new request.
REQ-024 Carry between nibbles SHALL propagate through the carry register, so W-bit results equal (A + B) mod 2^W and cout equals bit W of A + B.

Reset
REQ-025 While rst_n = 0: state = IDLE, busy = 0, done = 0, gnt_id = 0, sum = 0, cout = 0, carry = 0, idx = 0, RR pointer = 0. These values SHALL take effect immediately, independent of clk.
REQ-026 Reset asserted during RUN or DONE SHALL discard the operation with no done pulse. After release the block SHALL restart arbitration from IDLE.

Verification
REQ-027 NIB=4, req=01, a0=0x1234, b0=0x4321 -> done in the 5th cycle after the grant edge, gnt_id=0, sum=0x5555, cout=0.
REQ-028 req=10, a1=0xFFFF, b1=0x0001 -> sum=0x0000, cout=1, gnt_id=1 (carry ripples through all nibbles).
REQ-029 After reset, req=11 held continuously, a0+b0=0x0F0F+0x00F1, a1+b1=0x8000+0x8000 -> served in order req0, req1, req0, ... with results 0x1000/cout0 and 0x0000/cout1; done pulses spaced 6 cycles apart.
REQ-030 Grant req0, then change a0 to 0xFFFF and drop req during RUN -> result computed from the latched operands; done still pulses exactly once.
REQ-031 Pulse rst_n low during RUN -> busy, sum, cout and gnt_id go to 0 asynchronously and no done appears. With req=01 held, the next operation completes normally.
